// File: rtl/fifo_wr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
//   Shared definitions for the FIFO write-port arbiter: default parameter
//   values, the legacy-compatible FSM state encoding and a helper that sizes
//   the per-grant beat counter.
// ----------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ID_WIDTH_DEF   = 2;
  localparam int MAX_BURST_DEF  = 4;

  // State encoding shared with the rest of the FIFO control logic.
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  // Beat counter width: log2(MAX_BURST)+1 bits, so MAX_BURST-1 always fits.
  function automatic int beat_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the requester valid/ready/data bus and the FIFO write port.
//   Signals:
//     req_valid    per-requester valid, bit i = requester i
//     req_data     packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready    per-requester ready, at most one bit high
//     fifo_full    FIFO full flag
//     fifo_wr_en   FIFO write enable
//     fifo_data_in FIFO write data
//     grant_id     currently granted requester
//     busy         high while a requester holds the grant
//   Modports:
//     master  producer/FIFO side (drives requests and the full flag)
//     slave   arbiter side
// ----------------------------------------------------------------------------
interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_WIDTH   = ID_WIDTH_DEF
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic [ID_WIDTH-1:0]           grant_id;
  logic                          busy;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_priority_picker
//   Combinational round-robin search: returns the first set bit of req
//   starting at rr_ptr and wrapping modulo NUM_REQ.
//   Ports:
//     req     request vector
//     rr_ptr  search start position
//     found   any request present
//     idx     index of the winning request (0 when none)
// ----------------------------------------------------------------------------
module rr_priority_picker
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int ID_WIDTH = ID_WIDTH_DEF
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] idx
);

  always_comb begin
    // NOTE: every output is given a default before any conditional update so
    // no path leaves it unassigned and no latch is inferred.
    found = |req;
    idx   = '0;
    // Lowest set bit anywhere: the wrap-around result.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_WIDTH'(i);
    end
    // Lowest set bit at or above rr_ptr overrides the wrap-around result.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (ID_WIDTH'(i) >= rr_ptr)) idx = ID_WIDTH'(i);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares one FIFO write port among NUM_REQ valid/ready requesters using a
//   round-robin grant with bursts of at most MAX_BURST beats. Writes are
//   gated by fifo_full, so the FIFO never sees a write while full.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous reset, active high
//     bus   fifo_wr_arbiter_if.slave (requester bus + FIFO write port)
// ----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_WIDTH   = ID_WIDTH_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int BEAT_W = beat_width(MAX_BURST);

  logic                  state;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [BEAT_W-1:0]     beat_cnt;

  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic [ID_WIDTH-1:0]   next_ptr;
  logic [NUM_REQ-1:0]    ready;
  logic [DATA_WIDTH-1:0] data_mux;
  logic                  granted_valid;
  logic                  transfer;
  logic                  last_beat;

  rr_priority_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // Ready decode and data mux keyed on grant_id. The data mux follows
  // grant_id even outside GRANT, so after reset it presents slice 0.
  always_comb begin
    ready         = '0;
    data_mux      = bus.req_data[DATA_WIDTH-1:0];
    granted_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        ready[i]      = (state == ST_GRANT) && !bus.fifo_full;
        data_mux      = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        granted_valid = bus.req_valid[i];
      end
    end
  end

  assign transfer  = granted_valid && (state == ST_GRANT) && !bus.fifo_full;
  assign last_beat = (beat_cnt == BEAT_W'(MAX_BURST - 1));
  assign next_ptr  = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                          : grant_id + ID_WIDTH'(1);

  assign bus.req_ready    = ready;
  assign bus.fifo_wr_en   = transfer;
  assign bus.fifo_data_in = data_mux;
  assign bus.grant_id     = grant_id;
  assign bus.busy         = (state == ST_GRANT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else if (state == ST_IDLE) begin
      // Arbitration takes this one cycle; no write is issued in IDLE.
      if (pick_found) begin
        grant_id <= pick_idx;
        beat_cnt <= '0;
        state    <= ST_GRANT;
      end
    end else begin
      if (transfer && !last_beat) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end else if (transfer || !granted_valid) begin
        // Burst complete or requester dropped valid: hand the pointer on.
        // A stall (valid high, FIFO full) falls through and holds everything.
        rr_ptr <= next_ptr;
        state  <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed scenarios plus randomized traffic for fifo_wr_arbiter. The bench
//   plays the requesters (one data queue each) and an 8-deep FIFO.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DW         = 8;
  localparam int IDW        = 2;
  localparam int MAX_BURST  = 4;
  localparam int FIFO_DEPTH = 8;

  logic clk;
  logic rst;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IDW),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester data queues, FIFO contents and logs.
  logic [DW-1:0]  src [NUM_REQ][$];
  logic [DW-1:0]  fifo_q [$];
  logic [DW-1:0]  wlog [$];
  int             wcyc [$];
  logic [IDW-1:0] glog [$];

  bit auto_pop;
  bit pop_once;
  int cyc;
  bit prev_busy;

  int n_checks;
  int n_errors;

  // Sampled DUT outputs / inputs for the current cycle.
  logic [NUM_REQ-1:0] s_valid;
  logic [NUM_REQ-1:0] s_ready;
  logic               s_wr;
  logic [DW-1:0]      s_data;
  logic [IDW-1:0]     s_gid;
  logic               s_busy;
  logic               s_full;
  logic               s_rst;
  int                 s_cyc;

  task automatic drive_reqs();
    logic [NUM_REQ-1:0]    v;
    logic [NUM_REQ*DW-1:0] d;
    v = '0;
    d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src[i].size() > 0) begin
        v[i]          = 1'b1;
        d[i*DW +: DW] = src[i][0];
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
  endtask

  task automatic sample();
    @(negedge clk);
    s_valid = bus.req_valid;
    s_ready = bus.req_ready;
    s_wr    = bus.fifo_wr_en;
    s_data  = bus.fifo_data_in;
    s_gid   = bus.grant_id;
    s_busy  = bus.busy;
    s_full  = bus.fifo_full;
    s_rst   = rst;
    s_cyc   = cyc;
    cyc++;
    if (s_busy && !prev_busy) glog.push_back(s_gid);
    prev_busy = s_busy;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (s_wr) begin
      fifo_q.push_back(s_data);
      wlog.push_back(s_data);
      wcyc.push_back(s_cyc);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s_ready[i] && s_valid[i] && src[i].size() > 0) void'(src[i].pop_front());
    end
    if ((auto_pop || pop_once) && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pop_once      = 1'b0;
    bus.fifo_full = (fifo_q.size() >= FIFO_DEPTH);
    drive_reqs();
  endtask

  task automatic reset_assert();
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) src[i].delete();
    fifo_q.delete();
    wlog.delete();
    wcyc.delete();
    glog.delete();
    auto_pop      = 1'b0;
    pop_once      = 1'b0;
    bus.fifo_full = 1'b0;
    drive_reqs();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    rst       = 1'b0;
    cyc       = 0;
    prev_busy = 1'b0;
    drive_reqs();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset_assert();
    for (int i = 0; i < NUM_REQ; i++) src[i].push_back(8'(16*i + 12));
    drive_reqs();
    sample();
    n_checks++;
    if (s_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_ready: got %b expected 0000", s_ready); end
    n_checks++;
    if (s_wr !== 1'b0) begin n_errors++; $display("FAIL reset_wr_en: got %b expected 0", s_wr); end
    n_checks++;
    if (s_gid !== 2'd0) begin n_errors++; $display("FAIL reset_grant_id: got %0d expected 0", s_gid); end
    n_checks++;
    if (s_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", s_busy); end
    n_checks++;
    if (s_data !== 8'h0C) begin n_errors++; $display("FAIL reset_data_in: got %h expected 0c", s_data); end
    advance();
    release_rst();
    sample();
    n_checks++;
    if (s_busy !== 1'b0) begin n_errors++; $display("FAIL reset_arb_cycle_busy: got %b expected 0", s_busy); end
    advance();
    sample();
    n_checks++;
    if (s_busy !== 1'b1) begin n_errors++; $display("FAIL reset_first_grant_busy: got %b expected 1", s_busy); end
    n_checks++;
    if (s_gid !== 2'd0) begin n_errors++; $display("FAIL reset_first_grant_id: got %0d expected 0", s_gid); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_round_robin();
    int sent [NUM_REQ];
    int order [6] = '{0, 1, 2, 3, 0, 1};
    int g;
    reset_assert();
    for (int i = 0; i < NUM_REQ; i++) begin
      sent[i] = 0;
      for (int n = 0; n < 8; n++) src[i].push_back(8'(16*i + n));
    end
    auto_pop = 1'b1;
    release_rst();
    for (int c = 0; c < 30; c++) begin
      sample();
      advance();
    end
    n_checks++;
    if (wlog.size() != 24) begin n_errors++; $display("FAIL rr_write_count: got %0d expected 24", wlog.size()); end
    for (int w = 0; w < 24 && w < wlog.size(); w++) begin
      g = order[w/4];
      n_checks++;
      if (wlog[w] !== 8'(16*g + sent[g]))
        begin n_errors++; $display("FAIL rr_data[%0d]: got %h expected %h", w, wlog[w], 8'(16*g + sent[g])); end
      sent[g]++;
      n_checks++;
      if (wcyc[w] != 5*(w/4) + 1 + (w%4))
        begin n_errors++; $display("FAIL rr_cycle[%0d]: got %0d expected %0d", w, wcyc[w], 5*(w/4) + 1 + (w%4)); end
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (k >= glog.size()) begin n_errors++; $display("FAIL rr_grant[%0d]: got none expected %0d", k, order[k]); end
      else if (glog[k] !== 2'(order[k]))
        begin n_errors++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", k, glog[k], order[k]); end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_early_release();
    bit            exp_busy;
    bit            exp_wr;
    logic [DW-1:0] exp_data;
    reset_assert();
    src[2].push_back(8'hA5);
    src[2].push_back(8'hA6);
    auto_pop = 1'b1;
    release_rst();
    for (int c = 0; c < 6; c++) begin
      sample();
      exp_busy = (c >= 1 && c <= 3) || c == 5;
      exp_wr   = (c == 1 || c == 2 || c == 5);
      exp_data = (c == 1) ? 8'hA5 : (c == 2) ? 8'hA6 : 8'hB1;
      n_checks++;
      if (s_busy !== exp_busy) begin n_errors++; $display("FAIL early_busy c%0d: got %b expected %b", c, s_busy, exp_busy); end
      n_checks++;
      if (s_wr !== exp_wr) begin n_errors++; $display("FAIL early_wr_en c%0d: got %b expected %b", c, s_wr, exp_wr); end
      if (exp_wr) begin
        n_checks++;
        if (s_data !== exp_data) begin n_errors++; $display("FAIL early_data c%0d: got %h expected %h", c, s_data, exp_data); end
      end
      if (c == 5) begin
        n_checks++;
        if (s_gid !== 2'd1) begin n_errors++; $display("FAIL early_next_grant: got %0d expected 1", s_gid); end
      end
      advance();
      if (c == 3) begin
        src[1].push_back(8'hB1);
        drive_reqs();
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_full_stall();
    bit exp_busy;
    bit exp_wr;
    reset_assert();
    for (int n = 0; n < 8; n++) src[0].push_back(8'(8'h40 + n));
    src[0].push_back(8'h77);
    src[0].push_back(8'h78);
    src[0].push_back(8'h79);
    src[0].push_back(8'h7A);
    src[0].push_back(8'h7B);
    release_rst();
    for (int c = 0; c < 21; c++) begin
      sample();
      exp_wr   = (c >= 1 && c <= 4) || (c >= 6 && c <= 9) || (c >= 15 && c <= 18) || c == 20;
      exp_busy = (c >= 1 && c <= 4) || (c >= 6 && c <= 9) || (c >= 11 && c <= 18) || c == 20;
      n_checks++;
      if (s_wr !== exp_wr) begin n_errors++; $display("FAIL full_wr_en c%0d: got %b expected %b", c, s_wr, exp_wr); end
      n_checks++;
      if (s_busy !== exp_busy) begin n_errors++; $display("FAIL full_busy c%0d: got %b expected %b", c, s_busy, exp_busy); end
      if (c >= 11 && c <= 14) begin
        n_checks++;
        if (s_ready !== 4'b0000) begin n_errors++; $display("FAIL full_ready c%0d: got %b expected 0000", c, s_ready); end
      end
      if (c == 15) begin
        n_checks++;
        if (s_ready !== 4'b0001) begin n_errors++; $display("FAIL full_resume_ready: got %b expected 0001", s_ready); end
        n_checks++;
        if (s_data !== 8'h77) begin n_errors++; $display("FAIL full_resume_data: got %h expected 77", s_data); end
      end
      if (c == 20) begin
        n_checks++;
        if (s_data !== 8'h7B) begin n_errors++; $display("FAIL full_next_burst_data: got %h expected 7b", s_data); end
      end
      if (c == 14) auto_pop = 1'b1;
      advance();
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_fairness();
    logic [DW-1:0] exp_w [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h00, 8'h01, 8'h02, 8'h03,
                                 8'h34, 8'h35, 8'h36, 8'h37, 8'h04, 8'h05, 8'h06, 8'h07};
    int exp_g [4] = '{3, 0, 3, 0};
    reset_assert();
    for (int n = 0; n < 8; n++) src[3].push_back(8'(8'h30 + n));
    auto_pop = 1'b1;
    release_rst();
    sample();
    advance();
    for (int n = 0; n < 8; n++) src[0].push_back(8'(n));
    drive_reqs();
    for (int c = 1; c < 20; c++) begin
      sample();
      advance();
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= glog.size()) begin n_errors++; $display("FAIL fair_grant[%0d]: got none expected %0d", k, exp_g[k]); end
      else if (glog[k] !== 2'(exp_g[k]))
        begin n_errors++; $display("FAIL fair_grant[%0d]: got %0d expected %0d", k, glog[k], exp_g[k]); end
    end
    for (int w = 0; w < 16; w++) begin
      n_checks++;
      if (w >= wlog.size()) begin n_errors++; $display("FAIL fair_data[%0d]: got none expected %h", w, exp_w[w]); end
      else if (wlog[w] !== exp_w[w])
        begin n_errors++; $display("FAIL fair_data[%0d]: got %h expected %h", w, wlog[w], exp_w[w]); end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_mid_burst_reset();
    reset_assert();
    for (int n = 0; n < 8; n++) src[1].push_back(8'(8'h50 + n));
    auto_pop = 1'b1;
    release_rst();
    for (int c = 0; c < 3; c++) begin
      sample();
      advance();
    end
    // Third beat of req1's burst is on the bus now; reset lands on top of it.
    rst = 1'b1;
    src[3].push_back(8'h90);
    drive_reqs();
    sample();
    n_checks++;
    if (s_ready !== 4'b0000) begin n_errors++; $display("FAIL midrst_ready: got %b expected 0000", s_ready); end
    n_checks++;
    if (s_wr !== 1'b0) begin n_errors++; $display("FAIL midrst_wr_en: got %b expected 0", s_wr); end
    n_checks++;
    if (s_busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %b expected 0", s_busy); end
    n_checks++;
    if (s_gid !== 2'd0) begin n_errors++; $display("FAIL midrst_grant_id: got %0d expected 0", s_gid); end
    n_checks++;
    if (s_data !== 8'h00) begin n_errors++; $display("FAIL midrst_data_in: got %h expected 00", s_data); end
    advance();
    n_checks++;
    if (wlog.size() != 2) begin n_errors++; $display("FAIL midrst_write_count: got %0d expected 2", wlog.size()); end
    release_rst();
    sample();
    n_checks++;
    if (s_busy !== 1'b0) begin n_errors++; $display("FAIL midrst_arb_busy: got %b expected 0", s_busy); end
    advance();
    sample();
    n_checks++;
    if (s_gid !== 2'd1) begin n_errors++; $display("FAIL midrst_restart_grant: got %0d expected 1", s_gid); end
    n_checks++;
    if (s_wr !== 1'b1) begin n_errors++; $display("FAIL midrst_restart_wr_en: got %b expected 1", s_wr); end
    n_checks++;
    if (s_data !== 8'h52) begin n_errors++; $display("FAIL midrst_restart_data: got %h expected 52", s_data); end
    advance();
  endtask

  // --------------------------------------------------------------------------
  // Randomized traffic against a transaction-level model: an owner index
  // (meaningful while m_busy), a count of completed beats and a search start.
  task automatic test_random();
    bit                 m_busy;
    int                 m_owner;
    int                 m_beats;
    int                 m_ptr;
    bit                 found;
    int                 cand;
    logic [NUM_REQ-1:0] e_ready;
    logic               e_wr;
    logic [DW-1:0]      e_data;
    reset_assert();
    release_rst();
    m_busy  = 1'b0;
    m_owner = 0;
    m_beats = 0;
    m_ptr   = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (src[i].size() < 3 && $urandom_range(2) == 0) src[i].push_back(8'($urandom));
      end
      drive_reqs();
      pop_once = ($urandom_range(2) == 0);
      if (c % 250 == 100) rst = 1'b1;
      sample();

      if (s_rst) begin
        m_busy  = 1'b0;
        m_owner = 0;
        m_beats = 0;
        m_ptr   = 0;
      end
      e_wr    = m_busy && !s_full && s_valid[m_owner];
      e_ready = (m_busy && !s_full) ? 4'(1 << m_owner) : 4'b0000;
      e_data  = (src[m_owner].size() > 0) ? src[m_owner][0] : 8'h00;

      n_checks++;
      if (s_ready !== e_ready) begin n_errors++; $display("FAIL rand_ready c%0d: got %b expected %b", c, s_ready, e_ready); end
      n_checks++;
      if (s_wr !== e_wr) begin n_errors++; $display("FAIL rand_wr_en c%0d: got %b expected %b", c, s_wr, e_wr); end
      n_checks++;
      if (s_data !== e_data) begin n_errors++; $display("FAIL rand_data c%0d: got %h expected %h", c, s_data, e_data); end
      n_checks++;
      if (s_gid !== 2'(m_owner)) begin n_errors++; $display("FAIL rand_grant_id c%0d: got %0d expected %0d", c, s_gid, m_owner); end
      n_checks++;
      if (s_busy !== m_busy) begin n_errors++; $display("FAIL rand_busy c%0d: got %b expected %b", c, s_busy, m_busy); end

      if (!s_rst) begin
        if (!m_busy) begin
          if (s_valid != '0) begin
            found = 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
              cand = (m_ptr + k) % NUM_REQ;
              if (!found && s_valid[cand]) begin
                m_owner = cand;
                found   = 1'b1;
              end
            end
            m_busy  = 1'b1;
            m_beats = 0;
          end
        end else if (e_wr) begin
          m_beats++;
          if (m_beats == MAX_BURST) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % NUM_REQ;
          end
        end else if (!s_valid[m_owner]) begin
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % NUM_REQ;
        end
      end

      advance();
      rst = 1'b0;
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    auto_pop      = 1'b0;
    pop_once      = 1'b0;
    cyc           = 0;
    prev_busy     = 1'b0;
    n_checks      = 0;
    n_errors      = 0;

    test_reset();
    test_round_robin();
    test_early_release();
    test_full_stall();
    test_fairness();
    test_mid_burst_reset();
    test_random();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
